// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory request/acknowledge bus between mem_wb_stage and data memory
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output we, output addr, output wdata, input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access, branch resolution and one-cycle registered writeback stage
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] regDdata,
  input  logic [DATA_W-1:0] regBdata,
  input  logic              zero,
  input  logic [31:0]       PCNEXT,
  input  logic [REG_W-1:0]  regD,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  mem_wb_stage_if.master    dmem,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_regD,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WB} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_addr;
  logic [DATA_W-1:0] op_bdata;
  logic [31:0]       op_pc;
  logic [REG_W-1:0]  op_regD;
  logic              op_zero, op_branch, op_m2r, op_rw, op_store;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic accept, has_mem, bad_op, timeout_hit, in_wait, in_wb;

  assign accept      = in_valid & in_ready;
  assign has_mem     = mem_read | mem_write;
  assign bad_op      = has_mem & ((regDdata[1:0] != 2'b00) | (mem_read & mem_write));
  // the last permitted wait cycle is the one where cnt == TIMEOUT-1; an ack there still wins
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign in_wait     = (state == WAIT_ACK);
  assign in_wb       = (state == WB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = (has_mem && !bad_op) ? WAIT_ACK : WB;
      WAIT_ACK: if (dmem.ack || timeout_hit) state_nx = WB;
      WB:       state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      op_addr   <= '0;
      op_bdata  <= '0;
      op_pc     <= '0;
      op_regD   <= '0;
      op_zero   <= 1'b0;
      op_branch <= 1'b0;
      op_m2r    <= 1'b0;
      op_rw     <= 1'b0;
      op_store  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      op_addr   <= regDdata;
      op_bdata  <= regBdata;
      op_pc     <= PCNEXT;
      op_regD   <= regD;
      op_zero   <= zero;
      op_branch <= branch;
      op_m2r    <= mem_to_reg;
      op_rw     <= reg_write;
      op_store  <= mem_write;
      rdata_q   <= '0;
      err_q     <= bad_op;
    end else if (in_wait) begin
      if (dmem.ack)        rdata_q <= dmem.rdata;
      else if (timeout_hit) err_q  <= 1'b1;
      else                 cnt     <= cnt + 1'b1;
    end
  end

  // in_ready is held low during reset so every output reads 0 while reset is asserted
  assign in_ready   = (state == IDLE) & reset;

  assign dmem.req   = in_wait;
  assign dmem.we    = in_wait & op_store;
  assign dmem.addr  = in_wait ? op_addr  : '0;
  assign dmem.wdata = in_wait ? op_bdata : '0;

  assign wb_valid   = in_wb;
  assign wb_we      = in_wb & op_rw & ~err_q & (op_regD != '0);
  assign wb_regD    = in_wb ? op_regD : '0;
  assign wb_data    = in_wb ? (op_m2r ? rdata_q : op_addr) : '0;
  assign pc_src     = in_wb & op_branch & op_zero & ~err_q;
  assign pc_target  = in_wb ? op_pc : '0;
  assign mem_err    = in_wb & err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with directed vectors
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] regDdata, regBdata, PCNEXT;
  logic        zero;
  logic [4:0]  regD;
  logic        mem_read, mem_write, branch, mem_to_reg, reg_write;
  logic        wb_valid, wb_we, pc_src, mem_err;
  logic [4:0]  wb_regD;
  logic [31:0] wb_data, pc_target;

  mem_wb_stage_if #(.DATA_W(32)) dmem ();

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .regDdata(regDdata), .regBdata(regBdata), .zero(zero), .PCNEXT(PCNEXT), .regD(regD),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .dmem(dmem), .wb_valid(wb_valid), .wb_we(wb_we), .wb_regD(wb_regD),
    .wb_data(wb_data), .pc_src(pc_src), .pc_target(pc_target), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        pcs;
    logic [31:0] pct;
    logic        err;
    time         t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  int          ack_delay = 0;
  logic [31:0] ack_rdata = '0;
  int          cyc = 0;
  int          last_cycles = 0;
  int          total_req = 0;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic pcs, input logic [31:0] pct, input logic err);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.pcs = pcs; e.pct = pct; e.err = err; e.t = 0;
    return e;
  endfunction

  // memory model: acks on the ack_delay-th request cycle (0 = never); spurious acks when idle
  initial begin
    dmem.ack = 1'b0;
    dmem.rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem.req === 1'b1) begin
        cyc++;
        total_req++;
        if (cyc == 1) begin
          req_we = dmem.we; req_addr = dmem.addr; req_wdata = dmem.wdata;
        end else begin
          chk("req_stable", {dmem.we, dmem.addr, dmem.wdata}, {req_we, req_addr, req_wdata});
        end
        chk("in_ready_busy", in_ready, 1'b0);
        if (ack_delay != 0 && cyc == ack_delay) begin
          dmem.ack = 1'b1; dmem.rdata = ack_rdata;
        end else begin
          dmem.ack = 1'b0; dmem.rdata = '0;
        end
      end else begin
        dmem.ack = 1'b1;
        dmem.rdata = 32'hBAD0BAD0;
        if (cyc != 0) last_cycles = cyc;
        cyc = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (wb_valid === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_wb", 1'b1, 1'b0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_time",   $time,     e.t);
            chk("wb_we",     wb_we,     e.we);
            chk("wb_regD",   wb_regD,   e.rd);
            chk("wb_data",   wb_data,   e.data);
            chk("pc_src",    pc_src,    e.pcs);
            chk("pc_target", pc_target, e.pct);
            chk("mem_err",   mem_err,   e.err);
          end
        end else begin
          chk("idle_outputs", {wb_we, pc_src, mem_err, wb_data, pc_target, wb_regD}, '0);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic z,
                      input logic [31:0] pcn, input logic [4:0] rd, input logic mr,
                      input logic mw, input logic br, input logic m2r, input logic rw,
                      input int delay, input logic [31:0] rdat, input exp_t e,
                      input int obs, input bit push);
    int k;
    ack_delay = delay;
    ack_rdata = rdat;
    @(negedge clk);
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) chk("in_ready_wait", in_ready, 1'b1);
    regDdata = a; regBdata = b; zero = z; PCNEXT = pcn; regD = rd;
    mem_read = mr; mem_write = mw; branch = br; mem_to_reg = m2r; reg_write = rw;
    in_valid = 1'b1;
    @(posedge clk);
    e.t = $time + obs;
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; reg_write = 1'b0;
    regDdata = 32'hFFFF_FFFF; regBdata = 32'hFFFF_FFFF; PCNEXT = 32'hFFFF_FFFF; regD = 5'h1F;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
    #1;
  endtask

  int req_before;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    regDdata = '0; regBdata = '0; zero = 1'b0; PCNEXT = '0; regD = '0;
    mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {in_ready, dmem.req, wb_valid, wb_we, pc_src, mem_err, wb_data}, '0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);

    send(32'h15, 32'h0, 1'b0, 32'h0, 5'd3, 0, 0, 0, 0, 1, 0, '0,
         mk(1, 5'd3, 32'h15, 0, 32'h0, 0), 5, 1);
    drain();

    send(32'h40, 32'h0, 1'b0, 32'h0, 5'd7, 1, 0, 0, 1, 1, 3, 32'hDEADBEEF,
         mk(1, 5'd7, 32'hDEADBEEF, 0, 32'h0, 0), 35, 1);
    drain();
    chk("load_req_cycles", last_cycles, 3);
    chk("load_req_we", req_we, 1'b0);
    chk("load_req_addr", req_addr, 32'h40);

    send(32'h44, 32'h1234, 1'b0, 32'h0, 5'd0, 0, 1, 0, 0, 0, 1, '0,
         mk(0, 5'd0, 32'h44, 0, 32'h0, 0), 15, 1);
    drain();
    chk("store_req_cycles", last_cycles, 1);
    chk("store_req_we", req_we, 1'b1);
    chk("store_req_wdata", req_wdata, 32'h1234);

    req_before = total_req;
    send(32'h42, 32'h0, 1'b0, 32'h0, 5'd5, 1, 0, 0, 1, 1, 1, 32'h5555,
         mk(0, 5'd5, 32'h0, 0, 32'h0, 1), 5, 1);
    drain();
    chk("misaligned_no_req", total_req - req_before, 0);

    req_before = total_req;
    send(32'h48, 32'h9, 1'b0, 32'h0, 5'd6, 1, 1, 0, 0, 1, 1, 32'h5555,
         mk(0, 5'd6, 32'h48, 0, 32'h0, 1), 5, 1);
    drain();
    chk("rdwr_no_req", total_req - req_before, 0);

    send(32'h80, 32'h0, 1'b0, 32'h0, 5'd9, 1, 0, 0, 1, 1, 0, '0,
         mk(0, 5'd9, 32'h0, 0, 32'h0, 1), 165, 1);
    drain();
    chk("timeout_req_cycles", last_cycles, 16);

    send(32'h84, 32'h0, 1'b0, 32'h0, 5'd10, 1, 0, 0, 1, 1, 16, 32'hCAFEF00D,
         mk(1, 5'd10, 32'hCAFEF00D, 0, 32'h0, 0), 165, 1);
    drain();
    chk("ack16_req_cycles", last_cycles, 16);

    send(32'h0, 32'h0, 1'b1, 32'h100, 5'd0, 0, 0, 1, 0, 0, 0, '0,
         mk(0, 5'd0, 32'h0, 1, 32'h100, 0), 5, 1);
    send(32'h0, 32'h0, 1'b0, 32'h200, 5'd0, 0, 0, 1, 0, 0, 0, '0,
         mk(0, 5'd0, 32'h0, 0, 32'h200, 0), 5, 1);
    send(32'h77, 32'h0, 1'b0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, '0,
         mk(0, 5'd0, 32'h77, 0, 32'h0, 0), 5, 1);
    send(32'h50, 32'h0, 1'b0, 32'h0, 5'd12, 1, 0, 0, 0, 1, 2, 32'h999,
         mk(1, 5'd12, 32'h50, 0, 32'h0, 0), 25, 1);
    drain();

    send(32'h60, 32'h0, 1'b0, 32'h0, 5'd4, 1, 0, 0, 1, 1, 0, '0,
         mk(0, 5'd0, 32'h0, 0, 32'h0, 0), 0, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("pre_reset_req", dmem.req, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_reset_outputs", {in_ready, dmem.req, dmem.we, dmem.addr, wb_valid, mem_err}, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_reset_ready", in_ready, 1'b1);

    send(32'h21, 32'h0, 1'b0, 32'h0, 5'd2, 0, 0, 0, 0, 1, 0, '0,
         mk(1, 5'd2, 32'h21, 0, 32'h0, 0), 5, 1);
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
